// File: rtl/endstop_homing_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | endstop_homing_sequencer_if : host/channel signals of the homing seq |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface endstop_homing_sequencer_if #(
    parameter int WD_WIDTH = 32
);
    logic                start;
    logic                cancel;
    logic [1:0]          axis;
    logic                trig_polarity;
    logic [WD_WIDTH-1:0] seek_limit;
    logic [WD_WIDTH-1:0] release_limit;
    logic                ep_signal;
    logic                ep_changed;
    logic [31:0]         ep_pos;
    logic [31:0]         ep_bounce;
    logic [1:0]          mux_select;
    logic                abort_enabled;
    logic                abort_polarity;
    logic                unlock;
    logic                busy;
    logic                done;
    logic [2:0]          fault;
    logic [31:0]         home_pos;
    logic [31:0]         home_bounce;

    modport slave (
        input  start, cancel, axis, trig_polarity, seek_limit, release_limit,
               ep_signal, ep_changed, ep_pos, ep_bounce,
        output mux_select, abort_enabled, abort_polarity, unlock, busy, done,
               fault, home_pos, home_bounce
    );

    modport master (
        output start, cancel, axis, trig_polarity, seek_limit, release_limit,
               ep_signal, ep_changed, ep_pos, ep_bounce,
        input  mux_select, abort_enabled, abort_polarity, unlock, busy, done,
               fault, home_pos, home_bounce
    );
endinterface
`default_nettype wire

// File: rtl/endstop_homing_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | endstop_homing_sequencer : drives one endstop channel through homing |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module endstop_homing_sequencer #(
    parameter int WD_WIDTH = 32
) (
    input wire                         clk,
    input wire                         reset,
    endstop_homing_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_SETTLE  = 3'd2,
        S_SEEK    = 3'd3,
        S_CAPTURE = 3'd4,
        S_RELEASE = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    localparam logic [2:0] FLT_OK        = 3'd0;
    localparam logic [2:0] FLT_AXIS      = 3'd1;
    localparam logic [2:0] FLT_TRIGGERED = 3'd2;
    localparam logic [2:0] FLT_SEEK_TO   = 3'd3;
    localparam logic [2:0] FLT_REL_TO    = 3'd4;
    localparam logic [2:0] FLT_CANCEL    = 3'd5;
    localparam logic [WD_WIDTH-1:0] WD_ONE = {{(WD_WIDTH-1){1'b0}}, 1'b1};

    state_t              state_q;
    logic                pol_q;
    logic [WD_WIDTH-1:0] seek_lim_q;
    logic [WD_WIDTH-1:0] rel_lim_q;
    logic [WD_WIDTH-1:0] wd_q;
    logic [1:0]          mux_q;
    logic                abort_en_q;
    logic                unlock_q;
    logic                busy_q;
    logic                done_q;
    logic [2:0]          fault_q;
    logic [31:0]         home_pos_q;
    logic [31:0]         home_bounce_q;

    logic                at_trig;
    logic [WD_WIDTH-1:0] wd_d;
    logic                seek_timeout;
    logic                rel_timeout;
    logic                cancel_hit;
    logic                finish_d;
    logic [2:0]          fault_d;

    assign at_trig      = (bus.ep_signal == pol_q);
    assign wd_d         = (&wd_q) ? wd_q : wd_q + WD_ONE;
    assign seek_timeout = (seek_lim_q != '0) && (wd_q == seek_lim_q - WD_ONE);
    assign rel_timeout  = (rel_lim_q  != '0) && (wd_q == rel_lim_q  - WD_ONE);
    assign cancel_hit   = bus.cancel && (state_q != S_IDLE) && (state_q != S_FINISH);

    // Every route into FINISH is decided here so the register block applies it uniformly.
    always_comb begin
        finish_d = 1'b0;
        fault_d  = FLT_OK;
        if (cancel_hit) begin
            finish_d = 1'b1;
            fault_d  = FLT_CANCEL;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && (bus.axis == 2'd0)) begin
                        finish_d = 1'b1;
                        fault_d  = FLT_AXIS;
                    end
                end
                S_SETTLE: begin
                    if (at_trig) begin
                        finish_d = 1'b1;
                        fault_d  = FLT_TRIGGERED;
                    end
                end
                S_SEEK: begin
                    if (!(bus.ep_changed && at_trig) && seek_timeout) begin
                        finish_d = 1'b1;
                        fault_d  = FLT_SEEK_TO;
                    end
                end
                S_RELEASE: begin
                    if (!at_trig) begin
                        finish_d = 1'b1;
                        fault_d  = FLT_OK;
                    end else if (rel_timeout) begin
                        finish_d = 1'b1;
                        fault_d  = FLT_REL_TO;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            pol_q         <= 1'b0;
            seek_lim_q    <= '0;
            rel_lim_q     <= '0;
            wd_q          <= '0;
            mux_q         <= 2'd0;
            abort_en_q    <= 1'b0;
            unlock_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            fault_q       <= FLT_OK;
            home_pos_q    <= '0;
            home_bounce_q <= '0;
        end else begin
            unlock_q <= 1'b0;
            done_q   <= 1'b0;
            if (!cancel_hit) begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            pol_q         <= bus.trig_polarity;
                            seek_lim_q    <= bus.seek_limit;
                            rel_lim_q     <= bus.release_limit;
                            fault_q       <= FLT_OK;
                            home_pos_q    <= '0;
                            home_bounce_q <= '0;
                            busy_q        <= 1'b1;
                            mux_q         <= bus.axis;
                            unlock_q      <= (bus.axis != 2'd0);
                            state_q       <= S_ARM;
                        end
                    end
                    S_ARM:    state_q <= S_SETTLE;
                    S_SETTLE: begin
                        abort_en_q <= 1'b1;
                        wd_q       <= '0;
                        state_q    <= S_SEEK;
                    end
                    S_SEEK: begin
                        if (bus.ep_changed && at_trig) state_q <= S_CAPTURE;
                        else                           wd_q    <= wd_d;
                    end
                    // Channel holds position/bounce stable one cycle after its strobe.
                    S_CAPTURE: begin
                        home_pos_q    <= bus.ep_pos;
                        home_bounce_q <= bus.ep_bounce;
                        abort_en_q    <= 1'b0;
                        wd_q          <= '0;
                        state_q       <= S_RELEASE;
                    end
                    S_RELEASE: wd_q <= wd_d;
                    S_FINISH: begin
                        busy_q     <= 1'b0;
                        abort_en_q <= 1'b0;
                        mux_q      <= 2'd0;
                        state_q    <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
            if (finish_d) begin
                state_q    <= S_FINISH;
                fault_q    <= fault_d;
                done_q     <= 1'b1;
                abort_en_q <= 1'b0;
                mux_q      <= 2'd0;
            end
        end
    end

    assign bus.mux_select     = mux_q;
    assign bus.abort_enabled  = abort_en_q;
    assign bus.abort_polarity = pol_q;
    assign bus.unlock         = unlock_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.fault          = fault_q;
    assign bus.home_pos       = home_pos_q;
    assign bus.home_bounce    = home_bounce_q;
endmodule
`default_nettype wire

// File: tb/tb_endstop_homing_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_endstop_homing_sequencer : randomized homing runs vs event timeline|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_endstop_homing_sequencer;
    localparam int WD    = 32;
    localparam int NEVER = 1 << 30;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    endstop_homing_sequencer_if #(.WD_WIDTH(WD)) bus ();
    endstop_homing_sequencer #(.WD_WIDTH(WD)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;

    // Trial plan: events are counted in edges after the accepted start edge (edge 0).
    int          p_axis, p_pre, p_L, p_has_trig, p_k, p_RL, p_has_rel, p_j;
    int          p_c_seek, p_c_rel, p_rst_e;
    logic        p_pol;
    logic [31:0] p_pos, p_bounce;
    int          F, code, cap_e, trig_edge, rel_edge;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outcome of a trial from its event schedule: earliest event wins, cancel > trigger/release > timeout.
    task automatic plan();
        int s_end, r_end, why;
        if (p_L == 0 && p_has_trig == 0 && p_c_seek < 0) p_has_trig = 1;
        if (p_RL == 0 && p_has_rel == 0 && p_c_rel < 0) p_has_rel = 1;
        cap_e     = -1;
        trig_edge = p_has_trig != 0 ? 3 + p_k : NEVER;
        rel_edge  = (p_has_trig != 0 && p_has_rel != 0) ? 5 + p_k + p_j : NEVER;
        if (p_axis == 0) begin
            F = 0; code = 1;
        end else if (p_pre != 0) begin
            F = 2; code = 2;
        end else begin
            s_end = NEVER; why = 0;
            if (p_L != 0) begin s_end = p_L - 1; why = 3; end
            if (p_has_trig != 0 && p_k <= s_end) begin s_end = p_k; why = 0; end
            if (p_c_seek >= 0 && p_c_seek <= s_end) begin s_end = p_c_seek; why = 5; end
            if (why != 0) begin
                F = 3 + s_end; code = why;
            end else begin
                r_end = NEVER;
                if (p_RL != 0) begin r_end = p_RL - 1; why = 4; end
                if (p_has_rel != 0 && p_j <= r_end) begin r_end = p_j; why = 0; end
                if (p_c_rel >= 0 && p_c_rel <= r_end) begin r_end = p_c_rel; why = 5; end
                cap_e = 3 + p_k;
                F     = 5 + p_k + r_end;
                code  = why;
            end
        end
    endtask

    function automatic logic sig_at(input int x);
        if (p_pre != 0) return p_pol;
        return (x >= trig_edge && x < rel_edge) ? p_pol : ~p_pol;
    endfunction

    task automatic check_outputs(input int e);
        logic [31:0] exp_home, exp_bounce;
        bit          in_seek;
        exp_home   = (cap_e >= 0 && e > cap_e) ? p_pos    : 32'd0;
        exp_bounce = (cap_e >= 0 && e > cap_e) ? p_bounce : 32'd0;
        in_seek    = (p_axis != 0) && (p_pre == 0) && (e >= 2) &&
                     (e <= ((cap_e >= 0) ? cap_e - 1 : F - 1));
        check_val($sformatf("busy@%0d", e),   bus.busy,   32'(e <= F));
        check_val($sformatf("done@%0d", e),   bus.done,   32'(e == F));
        check_val($sformatf("unlock@%0d", e), bus.unlock, 32'(p_axis != 0 && e == 0));
        check_val($sformatf("fault@%0d", e),  bus.fault,  (e >= F) ? 32'(code) : 32'd0);
        check_val($sformatf("home_pos@%0d", e),    bus.home_pos,    exp_home);
        check_val($sformatf("home_bounce@%0d", e), bus.home_bounce, exp_bounce);
        check_val($sformatf("abort_pol@%0d", e),   bus.abort_polarity, 32'(p_pol));
        if (e != F && e != cap_e) begin
            check_val($sformatf("abort_en@%0d", e), bus.abort_enabled, 32'(in_seek));
            check_val($sformatf("mux@%0d", e), bus.mux_select,
                      (p_axis != 0 && e < F) ? 32'(p_axis) : 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_mux"},    bus.mux_select,     32'd0);
        check_val({tag, "_abort"},  bus.abort_enabled,  32'd0);
        check_val({tag, "_pol"},    bus.abort_polarity, 32'd0);
        check_val({tag, "_unlock"}, bus.unlock,         32'd0);
        check_val({tag, "_busy"},   bus.busy,           32'd0);
        check_val({tag, "_done"},   bus.done,           32'd0);
        check_val({tag, "_fault"},  bus.fault,          32'd0);
        check_val({tag, "_pos"},    bus.home_pos,       32'd0);
        check_val({tag, "_bounce"}, bus.home_bounce,    32'd0);
    endtask

    task automatic drive_inputs(input int x);
        bus.ep_signal  = sig_at(x);
        bus.ep_changed = (x == trig_edge) ||
                         (p_pre == 0 && x >= 3 && x < trig_edge && x <= F && $urandom_range(4) == 0);
        bus.ep_pos     = (x > trig_edge) ? p_pos    : $urandom;
        bus.ep_bounce  = (x > trig_edge) ? p_bounce : $urandom;
        bus.cancel     = (code == 5 && x == F);
        bus.start      = (x >= 1 && x <= F + 1 && $urandom_range(6) == 0);
        if (x >= 1) begin
            bus.axis          = 2'($urandom_range(3));
            bus.trig_polarity = 1'($urandom_range(1));
            bus.seek_limit    = 32'($urandom_range(3));
            bus.release_limit = 32'($urandom_range(3));
        end
    endtask

    task automatic reset_midcycle();
        #3 reset = 1'b0;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (2) begin
            @(posedge clk); #1;
            check_val("rst_no_done", bus.done, 32'd0);
            check_val("rst_no_busy", bus.busy, 32'd0);
        end
        #3 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_trial();
        plan();
        bus.axis          = 2'(p_axis);
        bus.trig_polarity = p_pol;
        bus.seek_limit    = 32'(p_L);
        bus.release_limit = 32'(p_RL);
        bus.ep_signal     = sig_at(0);
        bus.ep_changed    = 1'b0;
        bus.ep_pos        = $urandom;
        bus.ep_bounce     = $urandom;
        bus.cancel        = 1'b0;
        bus.start         = 1'b1;
        for (int e = 0; e <= F + 2; e++) begin
            @(posedge clk); #1;
            check_outputs(e);
            if (e == p_rst_e) begin
                reset_midcycle();
                return;
            end
            drive_inputs(e + 1);
        end
        bus.start      = 1'b0;
        bus.ep_changed = 1'b0;
        repeat (2) begin
            bus.cancel = 1'($urandom_range(1));
            @(posedge clk); #1;
            check_val("idle_busy",  bus.busy,     32'd0);
            check_val("idle_done",  bus.done,     32'd0);
            check_val("idle_fault", bus.fault,    32'(code));
            check_val("idle_home",  bus.home_pos, (cap_e >= 0) ? p_pos : 32'd0);
        end
        bus.cancel = 1'b0;
    endtask

    task automatic set_defaults();
        p_axis = 1; p_pol = 1'b1; p_pre = 0; p_L = 0; p_has_trig = 1; p_k = 2;
        p_RL = 0; p_has_rel = 1; p_j = 2; p_c_seek = -1; p_c_rel = -1; p_rst_e = -1;
        p_pos = $urandom; p_bounce = $urandom;
    endtask

    task automatic randomize_plan();
        set_defaults();
        p_axis     = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(3, 1));
        p_pol      = 1'($urandom_range(1));
        p_pre      = ($urandom_range(7) == 0) ? 1 : 0;
        p_L        = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(30, 1));
        p_has_trig = ($urandom_range(3) == 0) ? 0 : 1;
        p_k        = int'($urandom_range(30));
        p_RL       = ($urandom_range(1) == 0) ? 0 : int'($urandom_range(10, 1));
        p_has_rel  = ($urandom_range(3) == 0) ? 0 : 1;
        p_j        = int'($urandom_range(12));
        p_c_seek   = ($urandom_range(7) == 0) ? int'($urandom_range(30)) : -1;
        p_c_rel    = ($urandom_range(9) == 0) ? int'($urandom_range(12)) : -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.cancel = 1'b0; bus.axis = 2'd0; bus.trig_polarity = 1'b0;
        bus.seek_limit = '0; bus.release_limit = '0; bus.ep_signal = 1'b0;
        bus.ep_changed = 1'b0; bus.ep_pos = '0; bus.ep_bounce = '0;
        #2 check_all_zero("reset");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;

        // Normal home on axis 2, release five cycles after the strobe.
        set_defaults(); p_axis = 2; p_k = 3; p_j = 3; p_pos = 32'h1234; p_bounce = 32'h55;
        run_trial();
        // Illegal axis.
        set_defaults(); p_axis = 0; run_trial();
        // Switch already triggered at settle.
        set_defaults(); p_pre = 1; p_pol = 1'b0; run_trial();
        // Seek timeout after ten cycles.
        set_defaults(); p_axis = 3; p_L = 10; p_has_trig = 0; run_trial();
        // Release timeout with the switch held.
        set_defaults(); p_RL = 4; p_has_rel = 0; run_trial();
        // Cancel in seek, then a fresh start clears the fault.
        set_defaults(); p_has_trig = 0; p_c_seek = 4; run_trial();
        set_defaults(); p_axis = 2; run_trial();
        // Asynchronous reset during release, then a normal cycle.
        set_defaults(); p_k = 1; p_j = 10; p_rst_e = 7; run_trial();
        set_defaults(); p_axis = 3; p_pol = 1'b0; run_trial();

        for (int t = 0; t < 150; t++) begin
            randomize_plan();
            run_trial();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/endstop_homing_sequencer.md
# endstop_homing_sequencer

Sequences one shared endstop/debounce channel through a homing cycle for a selected axis. It programs the channel's position mux, abort enable/polarity and unlock, then waits for the debounced trigger edge and captures the latched trip position and bounce statistics. It waits for switch release, then reports completion or a fault code to the host register file. It sits between the host CSR block and the endstop-with-mux channel; the channel's abort output feeds the motion core.

## Interface
Parameters:
- `WD_WIDTH`, 32: watchdog counter width.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `start` in 1: one-cycle request to begin a cycle; honoured only in IDLE.
- `cancel` in 1: level/pulse; aborts any active cycle.
- `axis` in 2: axis to home (1=x, 2=y, 3=z; 0 is illegal).
- `trig_polarity` in 1: debounced signal level meaning "triggered".
- `seek_limit` in WD_WIDTH: max cycles to wait for trigger; 0 = no limit.
- `release_limit` in WD_WIDTH: max cycles to wait for release; 0 = no limit.
- `ep_signal` in 1: debounced endstop level from channel.
- `ep_changed` in 1: one-cycle debounced change strobe from channel.
- `ep_pos` in 32: latched trip position from channel.
- `ep_bounce` in 32: max bounce from channel.
- `mux_select` out 2: to channel; position source.
- `abort_enabled` out 1: to channel.
- `abort_polarity` out 1: to channel; equals latched `trig_polarity`.
- `unlock` out 1: one-cycle pulse to channel re-arming its capture.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse at end of cycle (success or fault).
- `fault` out 3: 0 ok, 1 illegal axis, 2 already triggered, 3 seek timeout, 4 release timeout, 5 cancelled; held until next accepted start.
- `home_pos` out 32: captured trip position, held until next accepted start.
- `home_bounce` out 32: captured bounce, held until next accepted start.

## Operation
- States: IDLE, ARM, SETTLE, SEEK, CAPTURE, RELEASE, FINISH.
- IDLE: `mux_select`=0, `abort_enabled`=0. On `start`: latch `axis`, `trig_polarity`, both limits; clear `fault`, `home_pos`, `home_bounce`. If axis==0, go to FINISH with fault 1; else go to ARM.
- ARM (1 cycle): drive `mux_select`=latched axis, pulse `unlock`, go to SETTLE.
- SETTLE (1 cycle): if `ep_signal`==polarity, go to FINISH with fault 2; else set `abort_enabled`=1, clear watchdog, go to SEEK.
- SEEK: on `ep_changed` && `ep_signal`==polarity, go to CAPTURE. Else if limit≠0 and watchdog==limit-1, go to FINISH with fault 3. Else increment watchdog.
- CAPTURE (1 cycle): register `ep_pos`→`home_pos` and `ep_bounce`→`home_bounce`; set `abort_enabled`=0; clear watchdog; go to RELEASE.
- RELEASE: on `ep_signal`!=polarity, go to FINISH with fault 0. Timeout handling as in SEEK, using `release_limit`, fault 4.
- FINISH (1 cycle): pulse `done`; set `abort_enabled`=0 and `mux_select`=0; go to IDLE.
- `cancel` in any non-IDLE, non-FINISH state overrides all other transitions: go to FINISH with fault 5. `cancel` in IDLE is ignored.
- `start` while busy is ignored; it is not queued.
- Watchdog saturates at all-ones and never wraps.
- `abort_polarity` is combinationally the latched polarity. It holds its last value in IDLE; reset value is 0.

## Timing
- Reset (`reset`=0), effective immediately: state IDLE; all outputs 0 (`mux_select`=0, `abort_enabled`=0, `abort_polarity`=0, `unlock`=0, `busy`=0, `done`=0, `fault`=0, `home_pos`=0, `home_bounce`=0); watchdog 0.
- Reset mid-cycle: return to IDLE with no `done` pulse.
- `start` sampled at edge N: `busy` goes high at N+1 and `unlock` is high during cycle N+1. The earliest `ep_changed` accepted in SEEK is at cycle N+3.
- `ep_changed` in SEEK at edge M: `home_pos` is valid from M+1. `ep_pos` is sampled at edge M+1, since the channel holds it stable after the strobe.
- Release at edge R: `done` is high during cycle R+1, and `busy` is low from R+2.
- Illegal axis: `done` is high during cycle N+1, with no `unlock` pulse.
- A seek timeout with limit L fires with exactly L SEEK cycles elapsed.
- `done` and `busy` are both high during the FINISH cycle.

## Test plan
- Normal home on axis 2: polarity 1, trigger strobe with `ep_pos`=0x1234, release 5 cycles later -> `mux_select`=2 during the cycle, one `unlock` pulse, `home_pos`=0x1234, `fault`=0, single `done` pulse.
- Axis 0: `start` with axis 0 -> `done` at N+1, `fault`=1, `unlock` never asserted.
- Already triggered: `ep_signal`=polarity at SETTLE -> `fault`=2, `abort_enabled` never asserted.
- Seek timeout: `seek_limit`=10, no strobe -> `fault`=3 after exactly 10 SEEK cycles. Repeat with `release_limit`=4 and a held trigger -> `fault`=4.
- Cancel and restart: `cancel` during SEEK -> `fault`=5, `abort_enabled` drops within 1 cycle. A `start` pulsed mid-cycle is ignored; a new `start` afterwards clears the fault.
- Async reset asserted during RELEASE -> all outputs 0 immediately, no `done` pulse; after deassertion, a normal cycle completes.
